// File: rtl/serv_ibus_pkg.sv
// Shared definitions for the instruction-bus responder: FSM encoding and the
// RVC length test applied to the low two bits of a 16-bit parcel.
package serv_ibus_pkg;

  localparam logic [1:0] RVC_FULL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    ACK  = 2'd3
  } state_t;

  // A parcel whose opcode bits are not 2'b11 is a complete 16-bit instruction.
  function automatic logic is_rvc(input logic [1:0] op);
    return op != RVC_FULL;
  endfunction

endpackage

// File: rtl/serv_ibus_line.sv
// One-entry instruction line buffer: remembers the last RAM word read and
// reports a hit for a queried word address.
module serv_ibus_line #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_inv,
  input  logic [AW-1:0] i_load_adr,
  input  logic [31:0]   i_load_dat,
  input  logic [AW-1:0] i_query_adr,
  output logic          o_hit,
  output logic [31:0]   o_dat
);

  logic          valid_q, valid_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;

  always_comb begin
    adr_d = adr_q;
    dat_d = dat_q;
    if (i_load) begin
      adr_d = i_load_adr;
      dat_d = i_load_dat;
    end
    // Invalidate wins over a coincident load so fence.i can never be missed.
    if (i_inv)       valid_d = 1'b0;
    else if (i_load) valid_d = 1'b1;
    else             valid_d = valid_q;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      valid_q <= valid_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign o_hit = valid_q && (adr_q == i_query_adr);
  assign o_dat = dat_q;

endmodule

// File: rtl/serv_ibus_resp.sv
// Instruction-bus responder: halfword-aligned fetches from a 32-bit synchronous RAM,
// splicing two words on straddling fetches and serving repeats from a line buffer.
module serv_ibus_resp
  import serv_ibus_pkg::*;
#(
  parameter int AW     = 10,
  parameter bit WITH_C = 1'b1
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_wb_cyc,
  input  logic [31:0]   i_wb_adr,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  input  logic          i_inv,
  output logic          o_mem_re,
  output logic [AW-1:0] o_mem_adr,
  input  logic [31:0]   i_mem_rdt
);

  localparam logic [AW-1:0] WORD_ONE = AW'(1);

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          re_q, re_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [15:0]   half0_q, half0_d;
  logic [AW-1:0] wa_q, wa_d;
  logic          hi_q, hi_d;

  logic [AW-1:0] wa;
  logic          hi;
  logic          line_hit, line_load;
  logic [AW-1:0] line_load_adr;
  logic [31:0]   line_dat;
  logic          unused_adr;

  assign wa         = i_wb_adr[AW+1:2];
  assign hi         = WITH_C && i_wb_adr[1];
  assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[0]};

  serv_ibus_line #(.AW(AW)) u_line (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_load      (line_load),
    .i_inv       (i_inv),
    .i_load_adr  (line_load_adr),
    .i_load_dat  (i_mem_rdt),
    .i_query_adr (wa),
    .o_hit       (line_hit),
    .o_dat       (line_dat)
  );

  always_comb begin
    state_d       = state_q;
    ack_d         = 1'b0;
    rdt_d         = rdt_q;
    re_d          = 1'b0;
    mem_adr_d     = mem_adr_q;
    half0_d       = half0_q;
    wa_d          = wa_q;
    hi_d          = hi_q;
    line_load     = 1'b0;
    line_load_adr = wa_q;

    case (state_q)
      IDLE: begin
        if (i_wb_cyc && !ack_q) begin
          wa_d = wa;
          hi_d = hi;
          if (line_hit && !hi) begin
            rdt_d   = line_dat;
            state_d = ACK;
          end else if (line_hit && is_rvc(line_dat[17:16])) begin
            rdt_d   = {16'h0000, line_dat[31:16]};
            state_d = ACK;
          end else if (line_hit) begin
            half0_d   = line_dat[31:16];
            re_d      = 1'b1;
            mem_adr_d = wa + WORD_ONE;
            state_d   = RD1;
          end else begin
            re_d      = 1'b1;
            mem_adr_d = wa;
            state_d   = RD0;
          end
        end
      end

      // RAM data is valid in the cycle after the read strobe, i.e. once re_q has dropped.
      RD0: begin
        if (!i_wb_cyc) state_d = IDLE;
        if (!re_q) begin
          line_load     = 1'b1;
          line_load_adr = wa_q;
          if (i_wb_cyc) begin
            if (!hi_q) begin
              rdt_d   = i_mem_rdt;
              state_d = ACK;
            end else if (is_rvc(i_mem_rdt[17:16])) begin
              rdt_d   = {16'h0000, i_mem_rdt[31:16]};
              state_d = ACK;
            end else begin
              half0_d   = i_mem_rdt[31:16];
              re_d      = 1'b1;
              mem_adr_d = wa_q + WORD_ONE;
              state_d   = RD1;
            end
          end
        end
      end

      RD1: begin
        if (!i_wb_cyc) state_d = IDLE;
        if (!re_q) begin
          line_load     = 1'b1;
          line_load_adr = wa_q + WORD_ONE;
          if (i_wb_cyc) begin
            rdt_d   = {i_mem_rdt[15:0], half0_q};
            state_d = ACK;
          end
        end
      end

      ACK: begin
        ack_d   = i_wb_cyc;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      rdt_q     <= '0;
      re_q      <= 1'b0;
      mem_adr_q <= '0;
      half0_q   <= '0;
      wa_q      <= '0;
      hi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
      re_q      <= re_d;
      mem_adr_q <= mem_adr_d;
      half0_q   <= half0_d;
      wa_q      <= wa_d;
      hi_q      <= hi_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_rdt  = rdt_q;
  assign o_mem_re  = re_q;
  assign o_mem_adr = mem_adr_q;

endmodule

// File: tb/tb_serv_ibus_resp.sv
// Bench for serv_ibus_resp: table of fetches with expected data/latency/RAM reads,
// a scoreboard of expected ack data, and hand-written abort/reset/invalidate sequences.
module tb_serv_ibus_resp;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_wb_cyc;
  logic [31:0]   i_wb_adr;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack;
  logic          i_inv;
  logic          o_mem_re;
  logic [AW-1:0] o_mem_adr;
  logic [31:0]   i_mem_rdt;

  serv_ibus_resp #(.AW(AW), .WITH_C(1'b1)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_wb_cyc  (i_wb_cyc),
    .i_wb_adr  (i_wb_adr),
    .o_wb_rdt  (o_wb_rdt),
    .o_wb_ack  (o_wb_ack),
    .i_inv     (i_inv),
    .o_mem_re  (o_mem_re),
    .o_mem_adr (o_mem_adr),
    .i_mem_rdt (i_mem_rdt)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model plus a log of the reads it performs.
  logic [31:0]   ram [0:(1<<AW)-1];
  int            rd_count = 0;
  logic [AW-1:0] rd_last = '0;
  logic [AW-1:0] rd_prev = '0;

  always @(posedge clk) begin
    if (o_mem_re) begin
      i_mem_rdt <= ram[o_mem_adr];
      rd_count  <= rd_count + 1;
      rd_prev   <= rd_last;
      rd_last   <= o_mem_adr;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ack_total = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected instruction word.
  always @(negedge clk) begin
    if (o_wb_ack) begin
      ack_total++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        chk("ack_rdt", o_wb_rdt, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; drives one fetch and checks latency, RAM reads and ack width.
  task automatic fetch(input logic [31:0] adr, input logic [31:0] rdt, input int lat,
                       input int reads, input logic [AW-1:0] last_adr, input string name);
    int n0, l;
    bit got;
    n0  = rd_count;
    l   = 0;
    got = 1'b0;
    exp_q.push_back(rdt);
    i_wb_adr = adr;
    i_wb_cyc = 1'b1;
    while (!got && l < 20) begin
      @(negedge clk);
      if (o_wb_ack) got = 1'b1;
      else l++;
    end
    i_wb_cyc = 1'b0;
    chk({name, "_ack_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(l), 32'(lat));
    chk({name, "_reads"}, 32'(rd_count - n0), 32'(reads));
    if (reads > 0) chk({name, "_last_rd_adr"}, 32'(rd_last), 32'(last_adr));
    @(negedge clk);
    chk({name, "_ack_single"}, 32'(o_wb_ack), 32'd0);
  endtask

  typedef struct {
    logic [31:0]   adr;
    logic [31:0]   rdt;
    int            lat;
    int            reads;
    logic [AW-1:0] last_adr;
  } vec_t;

  vec_t vecs[12];
  int   ack_base;

  initial begin
    vecs[0]  = '{32'h0000_0000, 32'h0000_0013, 3, 1, 10'd0};  // aligned miss
    vecs[1]  = '{32'h0000_0000, 32'h0000_0013, 1, 0, 10'd0};  // aligned hit
    vecs[2]  = '{32'h0000_0002, 32'h0000_0000, 1, 0, 10'd0};  // upper-half compressed hit
    vecs[3]  = '{32'h0000_0014, 32'h4505_0513, 3, 1, 10'd5};
    vecs[4]  = '{32'h0000_0016, 32'h0000_4505, 1, 0, 10'd5};
    vecs[5]  = '{32'h0000_000A, 32'h0000_0297, 5, 2, 10'd3};  // split, both miss
    vecs[6]  = '{32'h0000_000C, 32'h1234_0000, 1, 0, 10'd3};
    vecs[7]  = '{32'h0000_000E, 32'h0000_1234, 1, 0, 10'd3};
    vecs[8]  = '{32'h0000_0008, 32'h0297_0001, 3, 1, 10'd2};
    vecs[9]  = '{32'h0000_000A, 32'h0000_0297, 3, 1, 10'd3};  // split, first word hit
    vecs[10] = '{32'hFFFF_F00C, 32'h1234_0000, 1, 0, 10'd3};  // high address bits ignored
    vecs[11] = '{32'h0000_0010, 32'hCAFE_F00D, 3, 1, 10'd4};

    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    ram[0]  = 32'h0000_0013;
    ram[2]  = 32'h0297_0001;
    ram[3]  = 32'h1234_0000;
    ram[4]  = 32'hCAFE_F00D;
    ram[5]  = 32'h4505_0513;
    ram[8]  = 32'h1111_2222;
    ram[9]  = 32'h3333_4444;
    ram[12] = 32'h5555_6666;

    i_rst = 1'b1; i_wb_cyc = 1'b0; i_wb_adr = '0; i_inv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(o_wb_ack), 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'd0);
    chk("rst_mem_re", 32'(o_mem_re), 32'd0);
    chk("rst_mem_adr", 32'(o_mem_adr), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      fetch(vecs[i].adr, vecs[i].rdt, vecs[i].lat, vecs[i].reads, vecs[i].last_adr,
            $sformatf("vec%0d", i));
      if (i == 5) chk("vec5_first_rd_adr", 32'(rd_prev), 32'd2);
    end

    // Wrap-around: word 1023 followed by word 0.
    ram[1023] = 32'h0093_5555;
    ram[0]    = 32'hDEAD_0000;
    fetch(32'h0000_0FFE, 32'h0000_0093, 5, 2, 10'd0, "wrap");
    chk("wrap_first_rd_adr", 32'(rd_prev), 32'd1023);

    // Invalidate between two fetches of the same word forces a re-read.
    fetch(32'h0000_0020, 32'h1111_2222, 3, 1, 10'd8, "inv_fill");
    fetch(32'h0000_0020, 32'h1111_2222, 1, 0, 10'd8, "inv_hit");
    i_inv = 1'b1;
    @(negedge clk);
    i_inv = 1'b0;
    fetch(32'h0000_0020, 32'h1111_2222, 3, 1, 10'd8, "inv_refetch");

    // Invalidate held across a load: data still returned, line left invalid.
    i_inv = 1'b1;
    fetch(32'h0000_0024, 32'h3333_4444, 3, 1, 10'd9, "inv_load");
    i_inv = 1'b0;
    fetch(32'h0000_0024, 32'h3333_4444, 3, 1, 10'd9, "inv_load_again");

    // Abort in RD0 once the word is on the bus: no ack, but the line still fills.
    ack_base = ack_total;
    i_wb_adr = 32'h0000_0030;
    i_wb_cyc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_wb_cyc = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_ack", 32'(ack_total - ack_base), 32'd0);
    fetch(32'h0000_0030, 32'h5555_6666, 1, 0, 10'd12, "abort_line_kept");

    // Reset asserted while in RD1: outputs clear at once, no ack, line invalid.
    ack_base = ack_total;
    i_wb_adr = 32'h0000_000A;
    i_wb_cyc = 1'b1;
    repeat (3) @(negedge clk);
    chk("rd1_mem_re_before_rst", 32'(o_mem_re), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("midrst_ack", 32'(o_wb_ack), 32'd0);
    chk("midrst_mem_re", 32'(o_mem_re), 32'd0);
    chk("midrst_mem_adr", 32'(o_mem_adr), 32'd0);
    chk("midrst_rdt", o_wb_rdt, 32'd0);
    i_wb_cyc = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_ack", 32'(ack_total - ack_base), 32'd0);
    fetch(32'h0000_0008, 32'h0297_0001, 3, 1, 10'd2, "after_rst_miss");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serv_ibus_resp.md
Name: serv_ibus_resp

Overview:
Instruction-bus responder: the memory-side end of the Wishbone ibus that serv_ctrl drives through o_ibus_adr.
- Accepts halfword-aligned fetch addresses, since the PC advances by 2 for compressed instructions.
- Reads a 32-bit-wide synchronous instruction RAM and returns a 32-bit instruction word with a single-cycle ack.
- Splices two RAM words when a fetch straddles a word boundary.
- Holds a one-entry line buffer, so sequential fetches within the last-read word are served without a RAM access.

Parameters:
AW, 10, RAM word-address width (RAM depth is 2^AW words).
WITH_C, 1, 1 = compressed support (halfword fetches); 0 = adr[1] ignored and every fetch is a single-word read.

Ports:
clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_wb_cyc  input  1  fetch request; held high by the initiator until ack.
i_wb_adr  input  32  fetch byte address; bit 0 is always 0; bits above AW+1 are ignored.
o_wb_rdt  output  32  instruction data; valid only while o_wb_ack is high.
o_wb_ack  output  1  single-cycle acknowledge, registered.
i_inv  input  1  line-buffer invalidate (fence.i).
o_mem_re  output  1  RAM read strobe, registered.
o_mem_adr  output  AW  RAM word address, registered.
i_mem_rdt  input  32  RAM read data, valid in the cycle after o_mem_re.

Behaviour:
- Reset (async, i_rst=1): state=IDLE, o_wb_ack=0, o_wb_rdt=0, o_mem_re=0, o_mem_adr=0, line_valid=0.
- Definitions: wa = i_wb_adr[AW+1:2]; hi = WITH_C & i_wb_adr[1].
- Line buffer: line_valid, line_adr[AW-1:0], line_dat[31:0]. A word address X hits when line_valid and line_adr==X.
- States: IDLE, RD0, RD1, ACK.
- IDLE, while i_wb_cyc=1 and o_wb_ack=0:
  - hi=0, wa hits: capture rdt=line_dat, go to ACK.
  - hi=0, miss: issue read of wa, go to RD0.
  - hi=1, wa hits, and line_dat[17:16]!=2'b11 (compressed): rdt={16'h0000, line_dat[31:16]}, go to ACK.
  - hi=1, wa hits, and line_dat[17:16]==2'b11: keep half0=line_dat[31:16], issue read of wa+1, go to RD1.
  - hi=1, wa misses: issue read of wa, go to RD0.
- RD0 (data arrives one cycle after the read was issued): load line buffer with {wa, i_mem_rdt}.
  - If hi=0: rdt=i_mem_rdt, go to ACK.
  - If hi=1: apply the same compressed test to i_mem_rdt[17:16]. Compressed: rdt={16'h0, i_mem_rdt[31:16]}, go to ACK. Otherwise: keep half0, read wa+1, go to RD1.
- RD1: rdt={i_mem_rdt[15:0], half0}; line buffer loaded with {wa+1, i_mem_rdt}; go to ACK.
- ACK: o_wb_ack=1 for exactly one cycle, o_wb_rdt valid; next state IDLE. A request is never re-sampled in the ack cycle.
- o_mem_re is a one-cycle pulse per read. o_mem_adr holds its last value between reads.
- Latency, from the edge that samples cyc to ack high:
  - hit: 1 cycle.
  - aligned miss: 3 cycles.
  - split fetch with first word hit: 3 cycles.
  - split fetch with both words missing: 5 cycles.
- Wrap-around: wa+1 is computed modulo 2^AW (word 2^AW-1 is followed by word 0).
- i_wb_cyc falling before ack: abort, return to IDLE, no ack. A RAM word already captured still updates the line buffer.
- i_inv: clears line_valid at the next edge.
  - i_inv has priority over a simultaneous line-buffer load, so line_valid=0 after that edge.
  - In-flight data is still returned to the initiator.
- Reset mid-operation: immediate return to the reset values; no ack for the pending fetch.
- Address bits [31:AW+2] are ignored; no error response exists.

Decomposition:
- Shared package serv_ibus_pkg: state encoding (IDLE/RD0/RD1/ACK as 2-bit localparams) and the constant RVC_FULL=2'b11 used for the compressed test.
- One sub-module: serv_ibus_line, the one-entry line buffer.
  - Inputs: load, inv, load address, load data.
  - Outputs: hit for a queried address, and the data.

Test Plan:
- Aligned miss after reset: RAM[0]=32'h00000013, cyc with adr=0 -> o_mem_re pulses with o_mem_adr=0, ack exactly 3 cycles after cyc sampled, rdt=32'h00000013.
- Line-buffer hit: RAM[5]=32'h4505_0513; fetch 0x14, then 0x16 -> second fetch acks in 1 cycle with no o_mem_re, rdt=32'h00004505 (compressed upper half).
- Split fetch with both words missing: RAM[2]=32'h0297_0001, RAM[3]=32'h1234_0000; fetch adr=0x0A -> reads of 2 then 3, ack at cycle 5, rdt=32'h00000297.
- Wrap-around: AW=10, RAM[1023]=32'h0093_xxxx, RAM[0]=32'hxxxx_0000; fetch adr=0xFFE -> o_mem_adr goes 1023 then 0, rdt=32'h00000093.
- Invalidate: fetch 0x20 (line loaded), pulse i_inv, fetch 0x20 again -> o_mem_re reasserted, ack latency 3.
- Abort and reset: cyc dropped in RD0 -> no ack, returns to IDLE. Async i_rst asserted mid-RD1 -> o_wb_ack=0 and line_valid=0 immediately, no ack after release.
